// File: rtl/frame_stream_reader.sv
// Raster frame-buffer reader with mirror/flip addressing. Read latency and sink
// backpressure are absorbed by a credit-managed FIFO feeding an Avalon-ST video stream.
module frame_stream_reader #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int CH_IN  = 4,
    parameter int CH_OUT = 10,
    parameter int RD_LAT = 1,
    parameter int AW     = 17
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  restart,
    input  logic [1:0]            mode,
    output logic [AW-1:0]         rd_addr,
    input  logic [3*CH_IN-1:0]    rd_data,
    output logic [3*CH_OUT-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  frame_done
);

    localparam int CW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int IW    = 3 * CH_IN;
    localparam int DEPTH = RD_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int NW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic v;
        logic sop;
        logic eop;
    } tag_t;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [IW-1:0] pix;
    } entry_t;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    mode_q;
    tag_t          addr_tag;
    tag_t          tag_q [RD_LAT];

    entry_t        fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [NW-1:0] fifo_count;

    logic          first_px;
    logic          last_col;
    logic          last_row;
    logic [1:0]    eff_mode;
    logic [CW-1:0] col_eff;
    logic [RW-1:0] row_eff;
    logic [NW-1:0] inflight;
    logic          issue;
    logic          fifo_push;
    logic          fifo_pop;
    entry_t        head;

    function automatic logic [CH_OUT-1:0] expand_ch(input logic [CH_IN-1:0] c);
        logic [CH_OUT-1:0] o;
        o = '0;
        for (int i = 0; i < CH_OUT; i++) begin
            o[CH_OUT-1-i] = c[CH_IN-1-(i % CH_IN)];
        end
        return o;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pixel 0 uses the live mode input; the rest of the frame uses the copy latched with it.
    always_comb begin
        first_px = (col == '0) && (row == '0);
        last_col = (col == CW'(WIDTH - 1));
        last_row = (row == RW'(HEIGHT - 1));
        eff_mode = first_px ? mode : mode_q;
        col_eff  = eff_mode[0] ? CW'(WIDTH - 1) - col : col;
        row_eff  = eff_mode[1] ? RW'(HEIGHT - 1) - row : row;
    end

    // NOTE: every always_comb output gets a value before any loop or branch, so no latch is inferred.
    always_comb begin
        inflight = NW'(addr_tag.v);
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + NW'(tag_q[i].v);
        end
    end

    // A slot freed by this cycle's transfer may be re-credited to a new read immediately.
    assign fifo_pop  = out_valid && out_ready;
    assign fifo_push = tag_q[RD_LAT-1].v;
    assign issue     = !restart &&
                       ((int'(fifo_count) + int'(inflight)) < (DEPTH + int'(fifo_pop)));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col      <= '0;
            row      <= '0;
            mode_q   <= '0;
            rd_addr  <= '0;
            addr_tag <= '0;
        end else if (restart) begin
            col      <= '0;
            row      <= '0;
            addr_tag <= '0;
        end else begin
            addr_tag.v   <= issue;
            addr_tag.sop <= issue && first_px;
            addr_tag.eop <= issue && last_col && last_row;
            if (issue) begin
                rd_addr <= AW'(row_eff) * AW'(WIDTH) + AW'(col_eff);
                if (first_px) begin
                    mode_q <= mode;
                end
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
        end else if (restart) begin
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= addr_tag;
            for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (restart) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + NW'(1);
                2'b01:   fifo_count <= fifo_count - NW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: the FIFO storage has no reset; the pointers and count decide what is visible.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= '{sop: tag_q[RD_LAT-1].sop, eop: tag_q[RD_LAT-1].eop, pix: rd_data};
        end
    end

    assign head       = fifo_mem[rd_ptr];
    assign out_valid  = (fifo_count != '0);
    assign out_sop    = out_valid && head.sop;
    assign out_eop    = out_valid && head.eop;
    assign frame_done = fifo_pop && head.eop;
    assign out_data   = out_valid ? {expand_ch(head.pix[IW-1 -: CH_IN]),
                                     expand_ch(head.pix[2*CH_IN-1 -: CH_IN]),
                                     expand_ch(head.pix[CH_IN-1:0])} : '0;

endmodule

// File: tb/tb_frame_stream_reader.sv
// Bench for frame_stream_reader: two instances (read latency 1 and 3) on a 4x3 frame,
// each checked by its own monitor against a shared scoreboard of expected beats.
module tb_frame_stream_reader;

    localparam int FW = 4;
    localparam int FH = 3;
    localparam logic [29:0] F80_PIX = {10'h3FF, 10'h222, 10'h000};

    typedef struct {
        logic [29:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        restart;
    logic [1:0]  mode;
    logic        ready_a, ready_b;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic [11:0] rd_data_a, rd_data_b;
    logic [29:0] out_data_a, out_data_b;
    logic        out_valid_a, out_valid_b;
    logic        out_sop_a, out_sop_b, out_eop_a, out_eop_b;
    logic        frame_done_a, frame_done_b;

    logic [11:0] ram [16];
    logic [11:0] rb0, rb1, rb2;

    beat_t q_a[$];
    beat_t q_b[$];
    beat_t held [2];
    bit    stalled [2];
    int    beats [2];
    int    checks = 0;
    int    errors = 0;
    bit    rand_ready = 1'b0;
    bit    stall = 1'b0;
    int    first_a, first_b;

    always #5 clk = ~clk;

    frame_stream_reader #(.WIDTH(FW), .HEIGHT(FH), .CH_IN(4), .CH_OUT(10), .RD_LAT(1), .AW(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .restart(restart), .mode(mode),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(ready_a), .out_sop(out_sop_a),
        .out_eop(out_eop_a), .frame_done(frame_done_a));

    frame_stream_reader #(.WIDTH(FW), .HEIGHT(FH), .CH_IN(4), .CH_OUT(10), .RD_LAT(3), .AW(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .restart(restart), .mode(mode),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(ready_b), .out_sop(out_sop_b),
        .out_eop(out_eop_b), .frame_done(frame_done_b));

    // Synchronous frame-buffer models with one and three clocks of read latency.
    always @(posedge clk) begin
        rd_data_a <= ram[rd_addr_a];
        rb0 <= ram[rd_addr_b];
        rb1 <= rb0;
        rb2 <= rb1;
    end
    assign rd_data_b = rb2;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [29:0] expand_model(input logic [11:0] w);
        logic [3:0] r, g, b;
        r = w[11:8];
        g = w[7:4];
        b = w[3:0];
        return {r, r, r[3:2], g, g, g[3:2], b, b, b[3:2]};
    endfunction

    task automatic push_frame(input logic [1:0] m);
        beat_t b;
        int r, c, a;
        for (int i = 0; i < FW * FH; i++) begin
            r = i / FW;
            c = i % FW;
            if (m[1]) r = FH - 1 - r;
            if (m[0]) c = FW - 1 - c;
            a = r * FW + c;
            b.data = (a == 7) ? F80_PIX : expand_model(ram[a]);
            b.sop  = (i == 0);
            b.eop  = (i == FW * FH - 1);
            q_a.push_back(b);
            q_b.push_back(b);
        end
    endtask

    task automatic monitor(input int idx, input logic v, input logic r, input logic [29:0] d,
                           input logic s, input logic e, input logic fd);
        beat_t exp;
        int n;
        if (!reset_n) begin
            stalled[idx] = 1'b0;
            return;
        end
        if (stalled[idx])
            check($sformatf("stall_hold[%0d]", idx), {v, s, e, d},
                  {1'b1, held[idx].sop, held[idx].eop, held[idx].data});
        if (v && r) begin
            n = (idx == 0) ? q_a.size() : q_b.size();
            check($sformatf("beat_pending[%0d]", idx), n != 0, 1'b1);
            if (n != 0) begin
                if (idx == 0) exp = q_a.pop_front();
                else          exp = q_b.pop_front();
                check($sformatf("beat[%0d]", idx), {s, e, d}, {exp.sop, exp.eop, exp.data});
                check($sformatf("frame_done[%0d]", idx), fd, exp.eop);
                beats[idx]++;
            end
        end else begin
            check($sformatf("frame_done_idle[%0d]", idx), fd, 1'b0);
        end
        stalled[idx] = v && !r && !restart;
        held[idx]    = '{data: d, sop: s, eop: e};
    endtask

    always @(negedge clk) monitor(0, out_valid_a, ready_a, out_data_a, out_sop_a, out_eop_a, frame_done_a);
    always @(negedge clk) monitor(1, out_valid_b, ready_b, out_data_b, out_sop_b, out_eop_b, frame_done_b);

    // FIFO overflow (write into a full FIFO without a matching read) and underflow guards.
    always @(negedge clk) begin
        if (reset_n) begin
            check("fifo_guard_a", {dut_a.fifo_push && !dut_a.fifo_pop && dut_a.fifo_count == 2'd3,
                                   dut_a.fifo_pop && dut_a.fifo_count == 2'd0}, 2'b00);
            check("fifo_guard_b", {dut_b.fifo_push && !dut_b.fifo_pop && dut_b.fifo_count == 3'd5,
                                   dut_b.fifo_pop && dut_b.fifo_count == 3'd0}, 2'b00);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        ready_a = (q_a.size() != 0) && !stall && (!rand_ready || $urandom_range(0, 1) == 1);
        ready_b = (q_b.size() != 0) && !stall && (!rand_ready || $urandom_range(0, 1) == 1);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && k < budget) begin
            step();
            k++;
        end
        check("drain_left", q_a.size() + q_b.size(), 0);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (beats[0] < n && k < budget) begin
            step();
            k++;
        end
        check("wait_beats", beats[0] >= n, 1'b1);
    endtask

    task automatic do_restart(input logic [1:0] m);
        restart = 1'b1;
        mode    = m;
        ready_a = 1'b0;
        ready_b = 1'b0;
        @(posedge clk);
        #1;
        restart = 1'b0;
        q_a.delete();
        q_b.delete();
        beats = '{0, 0};
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 12'(i);
        ram[7] = 12'hF80;
        reset_n = 1'b0;
        restart = 1'b0;
        mode    = 2'd0;
        ready_a = 1'b0;
        ready_b = 1'b0;
        beats   = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        check("reset_state_a", {rd_addr_a, out_valid_a, out_sop_a, out_eop_a, frame_done_a, out_data_a}, 0);
        check("reset_state_b", {rd_addr_b, out_valid_b, out_sop_b, out_eop_b, frame_done_b, out_data_b}, 0);

        // Normal raster, two frames back to back, full rate.
        push_frame(2'd0);
        push_frame(2'd0);
        reset_n = 1'b1;
        first_a = -1;
        first_b = -1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            step();
            if (first_a < 0 && out_valid_a) first_a = cyc;
            if (first_b < 0 && out_valid_b) first_b = cyc;
        end
        check("first_valid_lat1", first_a, 3);
        check("first_valid_lat3", first_b, 5);
        check("throughput_lat1", beats[0], 9);
        check("throughput_lat3", beats[1], 7);
        drain(200);

        // Random 50% backpressure on the continuing stream.
        rand_ready = 1'b1;
        push_frame(2'd0);
        push_frame(2'd0);
        drain(600);
        rand_ready = 1'b0;

        // Horizontal mirror held across two frames.
        do_restart(2'd1);
        push_frame(2'd1);
        push_frame(2'd1);
        drain(200);

        // Mirror+flip frame; a mode change mid-frame applies only from the next frame.
        do_restart(2'd3);
        push_frame(2'd3);
        push_frame(2'd0);
        wait_beats(5, 100);
        mode = 2'd0;
        drain(200);

        // Vertical flip interrupted by restart at beat 6.
        do_restart(2'd2);
        push_frame(2'd2);
        push_frame(2'd2);
        wait_beats(6, 100);
        do_restart(2'd0);
        push_frame(2'd0);
        drain(200);

        // Asynchronous reset during a stall, then restart with mode 0.
        do_restart(2'd1);
        push_frame(2'd1);
        wait_beats(4, 100);
        stall = 1'b1;
        repeat (3) step();
        #1;
        reset_n = 1'b0;
        mode    = 2'd0;
        #1;
        check("async_reset_a", {rd_addr_a, out_valid_a, out_sop_a, out_eop_a, out_data_a}, 0);
        check("async_reset_b", {rd_addr_b, out_valid_b, out_sop_b, out_eop_b, out_data_b}, 0);
        q_a.delete();
        q_b.delete();
        beats = '{0, 0};
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        stall   = 1'b0;
        push_frame(2'd0);
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
